ov7670_stream_gen: RTL and testbench



---
 rtl/ov7670_stream_gen.sv | 156 +++++++++++++++
 tb/tb_ov7670_stream_gen.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_stream_gen.sv
// OV7670 camera-side DVP transmitter model: pclk = clk/2, vsync/href/data launched on
// pclk falling edges, RGB565 test patterns sent high byte first.
module ov7670_stream_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_BLANK   = 288,
  parameter int V_ACTIVE  = 480,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 17,
  parameter int VFP_LINES = 10,
  parameter int BAR_SHIFT = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_rgb,
  output logic        cam_pclk,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam int L       = 2 * H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = VS_LINES + VBP_LINES + V_ACTIVE + VFP_LINES;
  localparam int HW      = $clog2(L + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam logic [HW-1:0] H_LAST = HW'(L - 1);
  localparam logic [HW-1:0] H_HREF = HW'(2 * H_ACTIVE);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] h, h_nxt;
  logic [VW-1:0] v, v_nxt, v_last;
  logic [1:0]    mode_q, mode_nxt;
  logic [15:0]   solid_q, solid_nxt;
  logic          vsync_nxt, href_nxt, done_nxt;
  logic [7:0]    data_nxt, cnt_nxt;
  logic [15:0]   x, y, pix;
  logic          fall;

  function automatic logic [VW-1:0] lines_last(input state_t s);
    case (s)
      VSYNC:   return VW'(VS_LINES - 1);
      VBP:     return VW'(VBP_LINES - 1);
      ACTIVE:  return VW'(V_ACTIVE - 1);
      default: return VW'(VFP_LINES - 1);
    endcase
  endfunction

  function automatic state_t phase_next(input state_t s);
    case (s)
      VSYNC:   return VBP;
      VBP:     return ACTIVE;
      ACTIVE:  return VFP;
      default: return IDLE;
    endcase
  endfunction

  function automatic logic [15:0] pattern(input logic [1:0] m, input logic [15:0] solid,
                                          input logic [15:0] px, input logic [15:0] py);
    logic [2:0] b;
    b = 3'(px >> BAR_SHIFT);
    case (m)
      2'd0:    return solid;
      2'd1:    return {{5{b[2]}}, {6{b[1]}}, {5{b[0]}}};
      2'd2:    return {py[7:0], px[7:0]};
      default: return (px[4] ^ py[4]) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // cam_pclk is about to go 1->0 on this edge: the only edge that launches new outputs
  assign fall = cam_pclk;

  always_comb begin
    state_nxt = state;
    h_nxt     = h;
    v_nxt     = v;
    mode_nxt  = mode_q;
    solid_nxt = solid_q;
    done_nxt  = 1'b0;
    cnt_nxt   = frame_cnt;
    v_last    = lines_last(state);
    if (fall) begin
      if (state == IDLE) begin
        if (enable) begin
          state_nxt = VSYNC;
          h_nxt     = '0;
          v_nxt     = '0;
          mode_nxt  = mode;
          solid_nxt = solid_rgb;
        end
      end else if (h != H_LAST) begin
        h_nxt = h + HW'(1);
      end else begin
        h_nxt = '0;
        if (v != v_last) begin
          v_nxt = v + VW'(1);
        end else begin
          v_nxt     = '0;
          state_nxt = phase_next(state);
          if (state == VFP) begin
            done_nxt = 1'b1;
            cnt_nxt  = frame_cnt + 8'd1;
            if (enable) begin
              state_nxt = VSYNC;
              mode_nxt  = mode;
              solid_nxt = solid_rgb;
            end
          end
        end
      end
    end
    // Outputs are decoded from the next position so they register on the same fall tick
    x         = 16'(h_nxt >> 1);
    y         = 16'(v_nxt);
    pix       = pattern(mode_nxt, solid_nxt, x, y);
    vsync_nxt = (state_nxt == VSYNC);
    href_nxt  = (state_nxt == ACTIVE) && (h_nxt < H_HREF);
    data_nxt  = 8'h00;
    if (href_nxt) data_nxt = h_nxt[0] ? pix[7:0] : pix[15:8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cam_pclk   <= 1'b0;
      state      <= IDLE;
      h          <= '0;
      v          <= '0;
      cam_vsync  <= 1'b0;
      cam_href   <= 1'b0;
      cam_data   <= 8'h00;
      frame_done <= 1'b0;
      frame_cnt  <= 8'h00;
    end else begin
      cam_pclk   <= ~cam_pclk;
      state      <= state_nxt;
      h          <= h_nxt;
      v          <= v_nxt;
      cam_vsync  <= vsync_nxt;
      cam_href   <= href_nxt;
      cam_data   <= data_nxt;
      frame_done <= done_nxt;
      frame_cnt  <= cnt_nxt;
    end
  end

  // Frame settings are only consumed after a frame start has loaded them
  always_ff @(posedge clk) begin
    mode_q  <= mode_nxt;
    solid_q <= solid_nxt;
  end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen: small-frame instances, captured frames checked against a
// hand-computed vector table, plus multi-frame, enable, mode-latch and reset sequences.
module tb_ov7670_stream_gen;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [1:0]  mode_a = 2'd0, mode_b = 2'd0;
  logic [15:0] solid_a = 16'h0, solid_b = 16'h0;
  logic        pclk_a, vs_a, hr_a, done_a;
  logic        pclk_b, vs_b, hr_b, done_b;
  logic [7:0]  data_a, cnt_a, data_b, cnt_b;

  always #5 clk = ~clk;

  // A: L=10, 5 lines/frame (50 periods). B: L=68, 5 lines/frame (340 periods), bars every 4 px.
  ov7670_stream_gen #(.H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(2), .VS_LINES(1),
                      .VBP_LINES(1), .VFP_LINES(1), .BAR_SHIFT(7)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .mode(mode_a), .solid_rgb(solid_a),
    .cam_pclk(pclk_a), .cam_vsync(vs_a), .cam_href(hr_a), .cam_data(data_a),
    .frame_done(done_a), .frame_cnt(cnt_a));

  ov7670_stream_gen #(.H_ACTIVE(32), .H_BLANK(4), .V_ACTIVE(2), .VS_LINES(1),
                      .VBP_LINES(1), .VFP_LINES(1), .BAR_SHIFT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .mode(mode_b), .solid_rgb(solid_b),
    .cam_pclk(pclk_b), .cam_vsync(vs_b), .cam_href(hr_b), .cam_data(data_b),
    .frame_done(done_b), .frame_cnt(cnt_b));

  localparam int FRAME_A = 50;
  localparam int FRAME_B = 340;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int viol  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output changes must only be visible while cam_pclk is low
  logic [9:0] prev_a = 10'h0, prev_b = 10'h0;
  always @(negedge clk) begin
    viol   <= viol + ((({vs_a, hr_a, data_a} != prev_a) && pclk_a) ? 1 : 0)
                   + ((({vs_b, hr_b, data_b} != prev_b) && pclk_b) ? 1 : 0);
    prev_a <= {vs_a, hr_a, data_a};
    prev_b <= {vs_b, hr_b, data_b};
  end

  bit          sel_b = 1'b0;
  logic        s_pclk, s_vs, s_hr, s_done;
  logic [7:0]  s_data;
  always_comb begin
    s_pclk = sel_b ? pclk_b : pclk_a;
    s_vs   = sel_b ? vs_b   : vs_a;
    s_hr   = sel_b ? hr_b   : hr_a;
    s_done = sel_b ? done_b : done_a;
    s_data = sel_b ? data_b : data_a;
  end

  typedef struct {
    bit          dut_b;
    logic [1:0]  mode;
    logic [15:0] solid;
    int          period;
    logic        exp_vs;
    logic        exp_hr;
    logic [7:0]  exp_d;
  } vec_t;

  vec_t        vecs [64];
  int          nv = 0;
  logic [9:0]  cap [FRAME_B];
  logic [15:0] bars [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic add(input bit b, input logic [1:0] m, input logic [15:0] s, input int p,
                     input logic vs, input logic hr, input logic [7:0] d);
    vecs[nv].dut_b  = b;
    vecs[nv].mode   = m;
    vecs[nv].solid  = s;
    vecs[nv].period = p;
    vecs[nv].exp_vs = vs;
    vecs[nv].exp_hr = hr;
    vecs[nv].exp_d  = d;
    nv++;
  endtask

  // From one pclk-high sample to the sample n periods later
  task automatic adv(input int n);
    repeat (2 * n) @(negedge clk);
  endtask

  task automatic wait_vs(output bit ok);
    ok = 1'b0;
    for (int g = 0; g < 2000; g++) begin
      @(negedge clk);
      if (s_pclk && s_vs) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int g = 0; g < lim; g++) begin
      @(negedge clk);
      if (s_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic capture(input bit b, input logic [1:0] m, input logic [15:0] s);
    bit ok;
    int n;
    n     = b ? FRAME_B : FRAME_A;
    sel_b = b;
    if (b) begin mode_b = m; solid_b = s; en_b = 1'b1; end
    else   begin mode_a = m; solid_a = s; en_a = 1'b1; end
    wait_vs(ok);
    if (b) en_b = 1'b0; else en_a = 1'b0;
    if (!ok) begin
      chk("capture_vsync_timeout", 32'(ok), 32'd1);
      return;
    end
    cap[0] = {s_vs, s_hr, s_data};
    for (int p = 1; p < n; p++) begin
      adv(1);
      cap[p] = {s_vs, s_hr, s_data};
    end
    @(negedge clk);
    chk("frame_done_after_last_byte", 32'(s_done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    bit   have;
    vec_t cur;
    int   t0, n;
    logic [7:0] c0;

    bars = '{16'h0000, 16'h001F, 16'h07E0, 16'h07FF, 16'hF800, 16'hF81F, 16'hFFE0, 16'hFFFF};

    // A, mode 2 ramp: sync/blank regions and both active lines
    add(1'b0, 2'd2, 16'h0, 0,  1'b1, 1'b0, 8'h00);
    add(1'b0, 2'd2, 16'h0, 9,  1'b1, 1'b0, 8'h00);
    add(1'b0, 2'd2, 16'h0, 10, 1'b0, 1'b0, 8'h00);
    add(1'b0, 2'd2, 16'h0, 20, 1'b0, 1'b1, 8'h00);
    add(1'b0, 2'd2, 16'h0, 23, 1'b0, 1'b1, 8'h01);
    add(1'b0, 2'd2, 16'h0, 27, 1'b0, 1'b1, 8'h03);
    add(1'b0, 2'd2, 16'h0, 28, 1'b0, 1'b0, 8'h00);
    add(1'b0, 2'd2, 16'h0, 29, 1'b0, 1'b0, 8'h00);
    add(1'b0, 2'd2, 16'h0, 30, 1'b0, 1'b1, 8'h01);
    add(1'b0, 2'd2, 16'h0, 31, 1'b0, 1'b1, 8'h00);
    add(1'b0, 2'd2, 16'h0, 32, 1'b0, 1'b1, 8'h01);
    add(1'b0, 2'd2, 16'h0, 33, 1'b0, 1'b1, 8'h01);
    add(1'b0, 2'd2, 16'h0, 34, 1'b0, 1'b1, 8'h01);
    add(1'b0, 2'd2, 16'h0, 35, 1'b0, 1'b1, 8'h02);
    add(1'b0, 2'd2, 16'h0, 36, 1'b0, 1'b1, 8'h01);
    add(1'b0, 2'd2, 16'h0, 37, 1'b0, 1'b1, 8'h03);
    add(1'b0, 2'd2, 16'h0, 38, 1'b0, 1'b0, 8'h00);
    add(1'b0, 2'd2, 16'h0, 49, 1'b0, 1'b0, 8'h00);
    // A, mode 0 solid F81F
    add(1'b0, 2'd0, 16'hF81F, 15, 1'b0, 1'b0, 8'h00);
    add(1'b0, 2'd0, 16'hF81F, 20, 1'b0, 1'b1, 8'hF8);
    add(1'b0, 2'd0, 16'hF81F, 21, 1'b0, 1'b1, 8'h1F);
    add(1'b0, 2'd0, 16'hF81F, 26, 1'b0, 1'b1, 8'hF8);
    add(1'b0, 2'd0, 16'hF81F, 27, 1'b0, 1'b1, 8'h1F);
    add(1'b0, 2'd0, 16'hF81F, 28, 1'b0, 1'b0, 8'h00);
    add(1'b0, 2'd0, 16'hF81F, 36, 1'b0, 1'b1, 8'hF8);
    add(1'b0, 2'd0, 16'hF81F, 37, 1'b0, 1'b1, 8'h1F);
    // B, mode 1 bars: first pixel of each bar (x = 4*b, line 0 starts at period 136)
    for (int b = 0; b < 8; b++) begin
      add(1'b1, 2'd1, 16'h0, 136 + 8 * b, 1'b0, 1'b1, bars[b][15:8]);
      add(1'b1, 2'd1, 16'h0, 137 + 8 * b, 1'b0, 1'b1, bars[b][7:0]);
    end
    add(1'b1, 2'd1, 16'h0, 200, 1'b0, 1'b0, 8'h00);
    // B, mode 3 checkerboard
    add(1'b1, 2'd3, 16'h0, 136, 1'b0, 1'b1, 8'h00);
    add(1'b1, 2'd3, 16'h0, 166, 1'b0, 1'b1, 8'h00);
    add(1'b1, 2'd3, 16'h0, 168, 1'b0, 1'b1, 8'hFF);
    add(1'b1, 2'd3, 16'h0, 169, 1'b0, 1'b1, 8'hFF);
    add(1'b1, 2'd3, 16'h0, 198, 1'b0, 1'b1, 8'hFF);
    add(1'b1, 2'd3, 16'h0, 204, 1'b0, 1'b1, 8'h00);
    add(1'b1, 2'd3, 16'h0, 236, 1'b0, 1'b1, 8'hFF);

    repeat (4) @(negedge clk);
    chk("rst_pclk",  32'(pclk_a), 32'd0);
    chk("rst_vsync", 32'(vs_a),   32'd0);
    chk("rst_href",  32'(hr_a),   32'd0);
    chk("rst_data",  32'(data_a), 32'd0);
    chk("rst_done",  32'(done_a), 32'd0);
    chk("rst_cnt",   32'(cnt_a),  32'd0);
    rst_n = 1'b1;

    have = 1'b0;
    for (int i = 0; i < nv; i++) begin
      if (!have || vecs[i].dut_b != cur.dut_b || vecs[i].mode != cur.mode ||
          vecs[i].solid != cur.solid) begin
        capture(vecs[i].dut_b, vecs[i].mode, vecs[i].solid);
        cur  = vecs[i];
        have = 1'b1;
      end
      chk($sformatf("vec%0d_m%0d_p%0d", i, vecs[i].mode, vecs[i].period),
          32'(cap[vecs[i].period]),
          32'({vecs[i].exp_vs, vecs[i].exp_hr, vecs[i].exp_d}));
    end

    // Continuous frames on A: period, pulse width, counter step
    sel_b = 1'b0; mode_a = 2'd2; en_a = 1'b1;
    wait_done(400, ok);
    chk("cont_first_done", 32'(ok), 32'd1);
    t0 = cyc; c0 = cnt_a;
    @(negedge clk);
    chk("done_width", 32'(done_a), 32'd0);
    wait_done(400, ok);
    chk("cont_second_done", 32'(ok), 32'd1);
    chk("frame_period_clk", 32'(cyc - t0), 32'd100);
    chk("frame_cnt_step", 32'(cnt_a), 32'(8'(c0 + 8'd1)));

    // Drop enable mid-frame: frame completes, then stays idle
    adv(15);
    en_a = 1'b0; c0 = cnt_a;
    wait_done(200, ok);
    chk("drop_en_done", 32'(ok), 32'd1);
    chk("drop_en_cnt", 32'(cnt_a), 32'(8'(c0 + 8'd1)));
    n = 0;
    repeat (300) begin
      @(negedge clk);
      if (vs_a || done_a || hr_a) n++;
    end
    chk("idle_after_drop", 32'(n), 32'd0);

    // Mode change mid-frame on B takes effect only on the next frame
    sel_b = 1'b1; mode_b = 2'd2; solid_b = 16'h0; en_b = 1'b1;
    wait_vs(ok);
    chk("mode_chg_vsync", 32'(ok), 32'd1);
    mode_b = 2'd3;
    adv(168);
    chk("old_mode_px16_hi", 32'(data_b), 32'h00);
    adv(1);
    chk("old_mode_px16_lo", 32'(data_b), 32'h10);
    adv(170);
    chk("vfp_last_vsync_low", 32'(vs_b), 32'd0);
    adv(1);
    chk("back_to_back_vsync", 32'(vs_b), 32'd1);
    en_b = 1'b0;
    adv(168);
    chk("new_mode_px16_hi", 32'(data_b), 32'hFF);
    adv(1);
    chk("new_mode_px16_lo", 32'(data_b), 32'hFF);
    wait_done(800, ok);
    chk("mode_chg_frame_end", 32'(ok), 32'd1);

    // Asynchronous reset during ACTIVE, then restart with a full VSYNC
    sel_b = 1'b0; mode_a = 2'd2; en_a = 1'b1;
    wait_vs(ok);
    chk("rst_test_vsync", 32'(ok), 32'd1);
    adv(22);
    chk("rst_test_in_active", 32'(hr_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs_a", 32'({pclk_a, vs_a, hr_a, data_a, done_a, cnt_a}), 32'd0);
    chk("async_rst_cnt_b", 32'(cnt_b), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_edge1", 32'({pclk_a, vs_a}), 32'b10);
    @(posedge clk); #1;
    chk("rel_edge2_vsync", 32'({pclk_a, vs_a}), 32'b01);
    n = 0;
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      if (pclk_a) begin
        if (vs_a) n++;
        else break;
      end
    end
    chk("restart_vsync_periods", 32'(n), 32'd10);
    chk("restart_cnt", 32'(cnt_a), 32'd0);
    en_a = 1'b0;
    repeat (4) @(negedge clk);

    chk("changes_while_pclk_high", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
